// File: rtl/glb_host_sequencer.sv
`timescale 1ns/1ps
// Host-side sequencer for one cluster: loads weight/iact GLBs from a stream, pushes them
// over the west-0 routers, runs NUM_ITER computations and streams the psums back out.
module glb_host_sequencer #(
    parameter int DATA_BITWIDTH  = 16,
    parameter int ADDR_BITWIDTH  = 6,
    parameter int W_LOAD_ADDR    = 0,
    parameter int A_LOAD_ADDR    = 10,
    parameter int PSUM_LOAD_ADDR = 0,
    parameter int kernel_size    = 3,
    parameter int act_size       = 5,
    parameter int X_dim          = 3,
    parameter int NUM_ITER       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     in_valid,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     write_en_wght,
    output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    output logic [DATA_BITWIDTH-1:0] w_data_wght,
    output logic                     write_en_iact,
    output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    output logic [DATA_BITWIDTH-1:0] w_data_iact,
    output logic                     west_enable_i_west_0_wght,
    output logic [3:0]               router_mode_west_0_wght,
    output logic                     west_enable_i_west_0_iact,
    output logic [3:0]               router_mode_west_0_iact,
    output logic [3:0]               router_mode_west_0_psum,
    output logic                     start,
    input  logic                     load_done,
    input  logic                     compute_done,
    output logic                     r_req_psum,
    output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
    input  logic [DATA_BITWIDTH-1:0] r_data_psum,
    output logic                     out_valid,
    output logic [DATA_BITWIDTH-1:0] out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = ADDR_BITWIDTH;
    localparam int DW = DATA_BITWIDTH;
    localparam logic [3:0]  MODE_WEST   = 4'd3;
    localparam logic [3:0]  MODE_CLOSED = 4'd11;
    localparam logic [15:0] W_LAST      = 16'(kernel_size * kernel_size - 1);
    localparam logic [15:0] A_LAST      = 16'(act_size * act_size - 1);
    localparam logic [15:0] PW_LAST     = 16'(kernel_size * kernel_size + 2);
    localparam logic [15:0] PA_LAST     = 16'(act_size * act_size + 2);
    localparam logic [15:0] DRAIN_LAST  = 16'd7;
    localparam logic [15:0] X_LAST      = 16'(X_dim - 1);
    localparam logic [15:0] ITER_LAST   = 16'(NUM_ITER - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_LOAD_I, S_PUSH_W, S_WAIT_LW, S_PUSH_I, S_WAIT_LI,
        S_START, S_WAIT_C, S_DRAIN, S_RD, S_CAP, S_OUT, S_FIN
    } state_t;

    typedef struct packed {
        logic          in_ready;
        logic          we_w;
        logic [AW-1:0] wa_w;
        logic [DW-1:0] wd_w;
        logic          we_i;
        logic [AW-1:0] wa_i;
        logic [DW-1:0] wd_i;
        logic          en_w;
        logic [3:0]    mode_w;
        logic          en_i;
        logic [3:0]    mode_i;
        logic          start;
        logic          r_req;
        logic [AW-1:0] r_addr;
        logic          out_valid;
        logic [DW-1:0] out_data;
        logic          busy;
        logic          done;
    } outs_t;

    function automatic outs_t reset_outs();
        outs_t o;
        o        = '0;
        o.mode_w = MODE_CLOSED;
        o.mode_i = MODE_CLOSED;
        return o;
    endfunction

    function automatic logic [AW-1:0] psum_addr(input logic [15:0] iter, input logic [15:0] j);
        return AW'(PSUM_LOAD_ADDR) + AW'(iter) * AW'(X_dim) + AW'(j);
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s, j_r, j_s, iter_r, iter_s;
    logic        ld_q_r, cd_q_r;
    outs_t       outs_r, outs_s;
    logic        hs_s, ld_rise_s, cd_rise_s;

    assign hs_s      = in_valid & outs_r.in_ready;
    assign ld_rise_s = load_done & ~ld_q_r;
    assign cd_rise_s = compute_done & ~cd_q_r;

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        j_s     = j_r;
        iter_s  = iter_r;
        outs_s       = outs_r;
        outs_s.we_w  = 1'b0;
        outs_s.we_i  = 1'b0;
        outs_s.start = 1'b0;
        outs_s.r_req = 1'b0;
        outs_s.done  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    state_s         = S_LOAD_W;
                    outs_s.busy     = 1'b1;
                    outs_s.in_ready = 1'b1;
                    cnt_s  = 16'd0;
                    j_s    = 16'd0;
                    iter_s = 16'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD_W: begin
                if (hs_s) begin
                    outs_s.we_w = 1'b1;
                    outs_s.wa_w = AW'(W_LOAD_ADDR) + AW'(cnt_r);
                    outs_s.wd_w = in_data;
                    if (cnt_r == W_LAST) begin
                        cnt_s   = 16'd0;
                        state_s = S_LOAD_I;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end else begin
                    state_s = S_LOAD_W;
                end
            end
            S_LOAD_I: begin
                if (hs_s) begin
                    outs_s.we_i = 1'b1;
                    outs_s.wa_i = AW'(A_LOAD_ADDR) + AW'(cnt_r);
                    outs_s.wd_i = in_data;
                    if (cnt_r == A_LAST) begin
                        cnt_s           = 16'd0;
                        outs_s.in_ready = 1'b0;
                        outs_s.en_w     = 1'b1;
                        outs_s.mode_w   = MODE_WEST;
                        state_s         = S_PUSH_W;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end else begin
                    state_s = S_LOAD_I;
                end
            end
            S_PUSH_W: begin
                if (cnt_r == PW_LAST) begin
                    cnt_s         = 16'd0;
                    outs_s.en_w   = 1'b0;
                    outs_s.mode_w = MODE_CLOSED;
                    state_s       = S_WAIT_LW;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            S_WAIT_LW: begin
                if (ld_rise_s) begin
                    outs_s.en_i   = 1'b1;
                    outs_s.mode_i = MODE_WEST;
                    state_s       = S_PUSH_I;
                end else begin
                    state_s = S_WAIT_LW;
                end
            end
            S_PUSH_I: begin
                if (cnt_r == PA_LAST) begin
                    cnt_s         = 16'd0;
                    outs_s.en_i   = 1'b0;
                    outs_s.mode_i = MODE_CLOSED;
                    state_s       = S_WAIT_LI;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            S_WAIT_LI: begin
                if (ld_rise_s) begin
                    outs_s.start = 1'b1;
                    state_s      = S_START;
                end else begin
                    state_s = S_WAIT_LI;
                end
            end
            S_START: state_s = S_WAIT_C;
            S_WAIT_C: begin
                if (cd_rise_s) begin
                    cnt_s   = 16'd0;
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_WAIT_C;
                end
            end
            S_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    cnt_s         = 16'd0;
                    outs_s.r_req  = 1'b1;
                    outs_s.r_addr = psum_addr(iter_r, j_r);
                    state_s       = S_RD;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            S_RD: state_s = S_CAP;
            S_CAP: begin
                outs_s.out_valid = 1'b1;
                outs_s.out_data  = r_data_psum;
                state_s          = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    outs_s.out_valid = 1'b0;
                    if (j_r != X_LAST) begin
                        j_s           = j_r + 16'd1;
                        outs_s.r_req  = 1'b1;
                        outs_s.r_addr = psum_addr(iter_r, j_r + 16'd1);
                        state_s       = S_RD;
                    end else if (iter_r != ITER_LAST) begin
                        j_s          = 16'd0;
                        iter_s       = iter_r + 16'd1;
                        outs_s.start = 1'b1;
                        state_s      = S_START;
                    end else begin
                        j_s         = 16'd0;
                        iter_s      = 16'd0;
                        outs_s.done = 1'b1;
                        outs_s.busy = 1'b0;
                        state_s     = S_FIN;
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            S_FIN: state_s = S_IDLE;
            default: begin
                state_s = S_IDLE;
                outs_s  = reset_outs();
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 16'd0;
            j_r     <= 16'd0;
            iter_r  <= 16'd0;
            outs_r  <= reset_outs();
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            j_r     <= j_s;
            iter_r  <= iter_s;
            outs_r  <= outs_s;
        end
    end

    // Previous-cycle copies of the cluster status levels for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_q_r <= 1'b0;
            cd_q_r <= 1'b0;
        end else begin
            ld_q_r <= load_done;
            cd_q_r <= compute_done;
        end
    end

    assign in_ready                  = outs_r.in_ready;
    assign write_en_wght             = outs_r.we_w;
    assign w_addr_wght               = outs_r.wa_w;
    assign w_data_wght               = outs_r.wd_w;
    assign write_en_iact             = outs_r.we_i;
    assign w_addr_iact               = outs_r.wa_i;
    assign w_data_iact               = outs_r.wd_i;
    assign west_enable_i_west_0_wght = outs_r.en_w;
    assign router_mode_west_0_wght   = outs_r.mode_w;
    assign west_enable_i_west_0_iact = outs_r.en_i;
    assign router_mode_west_0_iact   = outs_r.mode_i;
    assign router_mode_west_0_psum   = MODE_CLOSED;
    assign start                     = outs_r.start;
    assign r_req_psum                = outs_r.r_req;
    assign r_addr_psum               = outs_r.r_addr;
    assign out_valid                 = outs_r.out_valid;
    assign out_data                  = outs_r.out_data;
    assign busy                      = outs_r.busy;
    assign done                      = outs_r.done;
endmodule

// File: tb/tb_glb_host_sequencer.sv
`timescale 1ns/1ps
// Bench for glb_host_sequencer: behavioural cluster model plus write/psum scoreboards.
module tb_glb_host_sequencer;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int W_LOAD_ADDR = 0;
    localparam int A_LOAD_ADDR = 10;
    localparam int PSUM_LOAD_ADDR = 0;

    logic clk = 1'b0, reset = 1'b1, go = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, write_en_wght, write_en_iact, start, r_req_psum, out_valid, busy, done;
    logic [AW-1:0] w_addr_wght, w_addr_iact, r_addr_psum;
    logic [DW-1:0] w_data_wght, w_data_iact, out_data, r_data_psum;
    logic west_enable_i_west_0_wght, west_enable_i_west_0_iact, load_done, compute_done;
    logic [3:0] router_mode_west_0_wght, router_mode_west_0_iact, router_mode_west_0_psum;

    int checks = 0, failures = 0;
    logic [DW-1:0] stim [34];
    logic [DW-1:0] psum_ref [9];
    logic [AW+DW-1:0] wq [$];
    logic [AW+DW-1:0] aq [$];
    logic [DW-1:0] p_q [$];

    glb_host_sequencer #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .W_LOAD_ADDR(W_LOAD_ADDR),
        .A_LOAD_ADDR(A_LOAD_ADDR), .PSUM_LOAD_ADDR(PSUM_LOAD_ADDR),
        .kernel_size(3), .act_size(5), .X_dim(3), .NUM_ITER(3)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .write_en_wght(write_en_wght), .w_addr_wght(w_addr_wght), .w_data_wght(w_data_wght),
        .write_en_iact(write_en_iact), .w_addr_iact(w_addr_iact), .w_data_iact(w_data_iact),
        .west_enable_i_west_0_wght(west_enable_i_west_0_wght),
        .router_mode_west_0_wght(router_mode_west_0_wght),
        .west_enable_i_west_0_iact(west_enable_i_west_0_iact),
        .router_mode_west_0_iact(router_mode_west_0_iact),
        .router_mode_west_0_psum(router_mode_west_0_psum),
        .start(start), .load_done(load_done), .compute_done(compute_done),
        .r_req_psum(r_req_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- cluster model ----------------
    logic [DW-1:0] wmem [64];
    logic [DW-1:0] amem [64];
    logic [DW-1:0] pmem [64];
    int s_iter, ld_ph, ld_tmr, cd_ph, cd_tmr;
    logic wen_d, ien_d;

    function automatic logic [DW-1:0] cluster_psum(input int it, input int j);
        logic [DW-1:0] acc = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc += wmem[AW'(W_LOAD_ADDR + r*3 + c)] * amem[AW'(A_LOAD_ADDR + (it+r)*5 + j + c)];
        return acc;
    endfunction

    function automatic logic [DW-1:0] ref_psum(input int it, input int j);
        logic [DW-1:0] acc = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc += stim[r*3 + c] * stim[9 + (it+r)*5 + j + c];
        return acc;
    endfunction

    // GLB storage, psum read port, load_done and compute_done behaviour (both held high as levels)
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_done <= 1'b0; compute_done <= 1'b0; r_data_psum <= '0;
            s_iter <= 0; ld_ph <= 0; ld_tmr <= 0; cd_ph <= 0; cd_tmr <= 0;
            wen_d <= 1'b0; ien_d <= 1'b0;
        end else begin
            if (write_en_wght) wmem[w_addr_wght] <= w_data_wght;
            if (write_en_iact) amem[w_addr_iact] <= w_data_iact;
            if (r_req_psum) r_data_psum <= pmem[r_addr_psum];
            wen_d <= west_enable_i_west_0_wght;
            ien_d <= west_enable_i_west_0_iact;
            case (ld_ph)
                0: if (wen_d && !west_enable_i_west_0_wght) begin load_done <= 1'b0; ld_tmr <= 3; ld_ph <= 1; end
                1: if (ld_tmr == 0) begin load_done <= 1'b1; ld_ph <= 2; end else ld_tmr <= ld_tmr - 1;
                2: if (ien_d && !west_enable_i_west_0_iact) begin ld_tmr <= 6; ld_ph <= 3; end
                3: if (ld_tmr == 0) begin load_done <= 1'b0; ld_tmr <= 2; ld_ph <= 4; end else ld_tmr <= ld_tmr - 1;
                4: if (ld_tmr == 0) begin load_done <= 1'b1; ld_ph <= 0; end else ld_tmr <= ld_tmr - 1;
                default: ld_ph <= 0;
            endcase
            if (!busy) s_iter <= 0;
            if (busy && start) begin
                for (int j = 0; j < 3; j++)
                    pmem[AW'(PSUM_LOAD_ADDR + s_iter*3 + j)] <= cluster_psum(s_iter, j);
                s_iter <= s_iter + 1;
                if (!compute_done) begin cd_tmr <= 10; cd_ph <= 1; end
                else begin cd_tmr <= 15; cd_ph <= 2; end
            end else begin
                case (cd_ph)
                    1: if (cd_tmr == 0) begin compute_done <= 1'b1; cd_ph <= 0; end else cd_tmr <= cd_tmr - 1;
                    2: if (cd_tmr == 0) begin compute_done <= 1'b0; cd_tmr <= 2; cd_ph <= 3; end else cd_tmr <= cd_tmr - 1;
                    3: if (cd_tmr == 0) begin compute_done <= 1'b1; cd_ph <= 0; end else cd_tmr <= cd_tmr - 1;
                    default: cd_ph <= 0;
                endcase
            end
        end
    end

    // ---------------- stimulus / checking ----------------
    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctrl"}, {in_ready, write_en_wght, write_en_iact, west_enable_i_west_0_wght,
                 west_enable_i_west_0_iact, start, r_req_psum, out_valid, busy, done}, 32'd0);
        check_eq({tag, "_modes"}, {router_mode_west_0_wght, router_mode_west_0_iact, router_mode_west_0_psum}, 32'h0BBB);
        check_eq({tag, "_data_addr"}, 32'(|{w_addr_wght, w_data_wght, w_addr_iact, w_data_iact, r_addr_psum, out_data}), 32'd0);
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic drive_stream(input bit push);
        for (int i = 0; i < 34; i++) begin
            bit hs;
            int guard;
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 500) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = in_valid ? stim[i] : 16'hDEAD;
                hs = in_valid && in_ready;
                if (hs && push) begin
                    if (i < 9) wq.push_back({AW'(W_LOAD_ADDR + i), stim[i]});
                    else       aq.push_back({AW'(A_LOAD_ADDR + i - 9), stim[i]});
                end
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) check_eq("in_handshake_timeout", 32'd0, 32'd1);
            if (i == 8)  check_eq("in_ready_after_wght", in_ready, 32'd1);
            if (i == 33) check_eq("in_ready_drop", in_ready, 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_full(input bit bp_en, input bit use_ref);
        int cyc = 0, guard = 0, nw = 0, ni = 0, mode_bad = 0, start_bad = 0, bp_bad = 0;
        int nstart = 0, rq_idx = 0, stall_left = 0;
        int t_ld_rise = -1, t_ipush_end = 1 << 30, t_cd_rise = -1, t_start = 0;
        bit ld_prev, cd_prev, ien_prev = 1'b0, first_rd = 1'b0, bp_done = 1'b0, held_v = 1'b0, fin = 1'b0;
        logic [DW-1:0] held_d = '0;
        logic [AW+DW-1:0] e;
        ld_prev = load_done;
        cd_prev = compute_done;
        for (int it = 0; it < 3; it++)
            for (int j = 0; j < 3; j++)
                p_q.push_back(use_ref ? psum_ref[it*3 + j] : ref_psum(it, j));
        pulse_go();
        fork
            drive_stream(1'b1);
            begin
                while (!fin && guard < 4000) begin
                    @(negedge clk);
                    cyc++; guard++;
                    if (bp_en && out_valid && !bp_done) begin stall_left = 20; bp_done = 1'b1; end
                    if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
                    else out_ready = ($urandom_range(0, 3) != 0);
                    if (write_en_wght) begin
                        if (wq.size() == 0) check_eq("wght_extra_write", 32'd1, 32'd0);
                        else begin
                            e = wq.pop_front();
                            check_eq("wght_addr", w_addr_wght, e[DW +: AW]);
                            check_eq("wght_data", w_data_wght, e[DW-1:0]);
                        end
                    end
                    if (write_en_iact) begin
                        if (aq.size() == 0) check_eq("iact_extra_write", 32'd1, 32'd0);
                        else begin
                            e = aq.pop_front();
                            check_eq("iact_addr", w_addr_iact, e[DW +: AW]);
                            check_eq("iact_data", w_data_iact, e[DW-1:0]);
                        end
                    end
                    if (west_enable_i_west_0_wght) nw++;
                    if (west_enable_i_west_0_iact) ni++;
                    if (router_mode_west_0_wght != (west_enable_i_west_0_wght ? 4'd3 : 4'd11)) mode_bad++;
                    if (router_mode_west_0_iact != (west_enable_i_west_0_iact ? 4'd3 : 4'd11)) mode_bad++;
                    if (router_mode_west_0_psum != 4'd11) mode_bad++;
                    if (load_done && !ld_prev) t_ld_rise = cyc;
                    if (compute_done && !cd_prev) t_cd_rise = cyc;
                    if (ien_prev && !west_enable_i_west_0_iact) t_ipush_end = cyc;
                    ld_prev = load_done; cd_prev = compute_done; ien_prev = west_enable_i_west_0_iact;
                    if (start) begin
                        nstart++;
                        if (west_enable_i_west_0_wght || west_enable_i_west_0_iact) start_bad++;
                        if (nstart == 1) check_eq("ld_fresh_edge", 32'(t_ld_rise > t_ipush_end), 32'd1);
                        t_start = cyc;
                        first_rd = 1'b1;
                    end
                    if (r_req_psum) begin
                        check_eq("psum_raddr", r_addr_psum, 32'(PSUM_LOAD_ADDR + rq_idx));
                        rq_idx++;
                        if (out_valid) bp_bad++;
                        if (first_rd) begin
                            check_eq("cd_fresh_edge", 32'(t_cd_rise > t_start), 32'd1);
                            check_eq("drain_latency", 32'(cyc - t_cd_rise), 32'd9);
                            first_rd = 1'b0;
                        end
                    end
                    if (held_v && (!out_valid || out_data != held_d)) bp_bad++;
                    held_v = out_valid && !out_ready;
                    held_d = out_data;
                    if (out_valid && out_ready) begin
                        if (p_q.size() == 0) check_eq("psum_extra", 32'd1, 32'd0);
                        else check_eq("psum_data", out_data, p_q.pop_front());
                    end
                    if (done) begin
                        check_eq("busy_at_done", busy, 32'd0);
                        check_eq("psums_left", p_q.size(), 32'd0);
                        fin = 1'b1;
                    end
                end
            end
        join
        out_ready = 1'b0;
        if (!fin) check_eq("run_timeout", 32'd0, 32'd1);
        check_eq("wght_enable_cycles", nw, 32'd12);
        check_eq("iact_enable_cycles", ni, 32'd28);
        check_eq("router_modes", mode_bad, 32'd0);
        check_eq("start_with_enable", start_bad, 32'd0);
        check_eq("start_count", nstart, 32'd3);
        check_eq("psum_reads", rq_idx, 32'd9);
        check_eq("backpressure", bp_bad, 32'd0);
        check_eq("writes_left", wq.size() + aq.size(), 32'd0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 32'd0);
        p_q.delete(); wq.delete(); aq.delete();
    endtask

    initial begin
        psum_ref = '{16'd63, 16'd72, 16'd81, 16'd108, 16'd117, 16'd126, 16'd153, 16'd162, 16'd171};
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 34; i++) stim[i] = (i < 9) ? 16'd1 : 16'(i - 8);
        pulse_go();
        fork
            drive_stream(1'b0);
            begin
                int g = 0;
                while (!west_enable_i_west_0_iact && g < 1000) begin @(posedge clk); #1; g++; end
                check_eq("reach_push_iact", west_enable_i_west_0_iact, 32'd1);
                repeat (3) begin @(posedge clk); #1; end
                reset = 1'b0;
                #1 check_reset_outputs("midrun_reset");
            end
        join
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_full(1'b1, 1'b1);

        for (int i = 0; i < 34; i++) stim[i] = (i < 9) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 255));
        run_full(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glb_host_sequencer.md
# glb_host_sequencer

Host-side sequencer for one `HMNOC_1cluster_wpsum` cluster. It drives the initiator side of the cluster's GLB/router interface:
- accepts weights then input activations on a valid/ready stream and writes them into the weight and iact GLBs;
- pushes both GLBs into the PE array over the west-0 routers;
- issues `start` `NUM_ITER` times;
- reads back `X_dim` psums per iteration and streams them out.

It replaces manual host stimulus in system-level builds.

## Interface
- `DATA_BITWIDTH`, 16, data word width
- `ADDR_BITWIDTH`, 6, GLB address width
- `W_LOAD_ADDR`, 0, first weight GLB address
- `A_LOAD_ADDR`, 10, first iact GLB address
- `PSUM_LOAD_ADDR`, 0, first psum GLB address
- `kernel_size`, 3, weight count = kernel_size²
- `act_size`, 5, iact count = act_size²
- `X_dim`, 3, psums read per iteration
- `NUM_ITER`, 3, compute iterations per run

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `go` in 1: run request, sampled in IDLE
- `in_valid` in 1, `in_data` in DATA_BITWIDTH, `in_ready` out 1: load stream
- `write_en_wght` out 1, `w_addr_wght` out ADDR_BITWIDTH, `w_data_wght` out DATA_BITWIDTH: weight GLB write
- `write_en_iact` out 1, `w_addr_iact` out ADDR_BITWIDTH, `w_data_iact` out DATA_BITWIDTH: iact GLB write
- `west_enable_i_west_0_wght` out 1, `router_mode_west_0_wght` out 4: weight router control
- `west_enable_i_west_0_iact` out 1, `router_mode_west_0_iact` out 4: iact router control
- `router_mode_west_0_psum` out 4: psum router mode, held CLOSED
- `start` out 1, `load_done` in 1, `compute_done` in 1: cluster control
- `r_req_psum` out 1, `r_addr_psum` out ADDR_BITWIDTH, `r_data_psum` in DATA_BITWIDTH: psum GLB read
- `out_valid` out 1, `out_data` out DATA_BITWIDTH, `out_ready` in 1: psum stream
- `busy` out 1, `done` out 1

## Operation
- Router mode encodings: WEST=3, CLOSED=11.
- All outputs are registered.
- Reset values:
  - all enables, requests, `start`, `out_valid`, `busy`, `done` = 0;
  - all data and addresses = 0;
  - all router modes = CLOSED;
  - FSM in IDLE; counters = 0.
- Reset assertion in mid-run forces these values immediately. No partial state survives.

FSM states and transitions:
- IDLE: `go`=1 → LOAD_W; `busy` becomes 1. `go` is ignored in every other state.
- LOAD_W: `in_ready`=1. Each handshake produces, on the next cycle, a one-cycle `write_en_wght` with `w_addr_wght` = W_LOAD_ADDR+k and `w_data_wght` = `in_data`, for k = 0..kernel_size²−1. After the last word → LOAD_I.
- LOAD_I: same as LOAD_W on the iact port, addresses A_LOAD_ADDR+k for k = 0..act_size²−1. Then → PUSH_W, with `in_ready`=0.
- PUSH_W: `west_enable_i_west_0_wght`=1 and mode WEST for exactly kernel_size²+3 cycles. Then enable=0, mode CLOSED → WAIT_LW.
- WAIT_LW: wait for a rising edge (registered 0→1) of `load_done` → PUSH_I.
- PUSH_I: same as PUSH_W on the iact port, for act_size²+3 cycles → WAIT_LI.
- WAIT_LI: wait for a `load_done` rising edge → START.
- START: `start`=1 for one cycle → WAIT_C.
- WAIT_C: wait for a `compute_done` rising edge, then 8 drain cycles → RD.
  - Edge detection is used so a level left high from the previous iteration is not re-accepted.
- RD: `r_req_psum`=1 for one cycle, `r_addr_psum` = PSUM_LOAD_ADDR + iter·X_dim + j → CAP.
- CAP: latch `r_data_psum` into `out_data`, set `out_valid` → OUT.
- OUT: hold `out_valid` and `out_data` until `out_ready`. On handshake, j++:
  - j < X_dim → RD;
  - else iter++ and either iter < NUM_ITER → START, or → FIN.
- FIN: `done`=1 for one cycle, `busy`=0 → IDLE.

Address arithmetic:
- Computed at ADDR_BITWIDTH and wraps modulo 2^ADDR_BITWIDTH.
- Overlapping parameter sets are not checked.

## Timing
- Stream write latency: handshake at edge n → `write_en` high during cycle n+1. Back-to-back handshakes give back-to-back writes. `in_valid`=0 stalls with no write.
- `in_ready` drops in the cycle after the last accepted iact word.
- Psum read: request in cycle n; `r_data_psum` is valid and sampled at edge n+1. `out_valid` rises in cycle n+2.
- Minimum cost per psum is 3 cycles. `out_ready` held low stalls indefinitely with `out_data` stable.
- `load_done` or `compute_done` already high on entry to a wait state is not accepted until it falls and rises again.
- `start` is never asserted while any router enable is high.

## Test plan
- Reset: drive `reset`=0 mid-run, in PUSH_I → next sample shows all outputs at reset values and modes = 11; release and `go` → a full run restarts from LOAD_W.
- Full run against the cluster:
  - stimulus: weights all 1, iacts 1..25;
  - iter 0 psums: 63, 72, 81;
  - iter 1 psums: 108, 117, 126;
  - iter 2 psums: 153, 162, 171;
  - then one `done` pulse.
- Load stream gaps: toggle `in_valid` randomly → exactly 9 weight writes at addresses 0..8 and 25 iact writes at addresses 10..34, each with correct data and no duplicates.
- Router push: count enable-high cycles → weight enable high for 12 cycles, iact enable high for 28 cycles; modes are 3 while enabled and 11 otherwise.
- Level-held done: hold `compute_done` high across iterations → the second `start` is issued only after a fresh 0→1 edge.
- Backpressure: hold `out_ready`=0 for 20 cycles → `out_data` stable and no new `r_req_psum` is issued.
